updown_counter_mod: RTL

//  Parametrised up/down modulo counter; next generation of the lab counter.

---
 rtl/updown_counter_if.sv | 22 ++
 rtl/updown_counter_mod.sv | 89 ++++++++
 2 files changed

// File: rtl/updown_counter_if.sv
// Control/data bundle for updown_counter_mod: the master drives the strobes,
// and the counter returns the registered count and terminal-count pulse.
interface updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;

    modport master (
        output en, dir, load, load_val,
        input  count, tc
    );

    modport slave (
        input  en, dir, load, load_val,
        output count, tc
    );
endinterface

// File: rtl/updown_counter_mod.sv
// Parametrised up/down modulo counter with load, wrap/saturate and a terminal-count pulse.
// Optional enable prescaler is built only when COUNTER_PRESCALE_EN is defined.
module updown_counter_mod #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    updown_counter_if.slave  bus
);
    if (WIDTH < 2 || MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1 || PRESCALE < 1) begin : g_bad_params
        $error("updown_counter_mod: illegal parameter combination");
    end

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             step;
    logic             at_limit;
    logic [WIDTH-1:0] load_clamped;

`ifdef COUNTER_PRESCALE_EN
    // PRESCALE = 1 gives a 1-bit prescaler pinned at 0, so every enabled cycle steps.
    localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    assign step = bus.en && (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q;
        if (bus.load) begin
            pre_d = '0;
        end else if (bus.en) begin
            pre_d = step ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign step = bus.en;
`endif

    assign load_clamped = (bus.load_val > LIMIT) ? LIMIT : bus.load_val;
    assign at_limit     = bus.dir ? (count_q == LIMIT) : (count_q == '0);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (bus.load) begin
            count_d = load_clamped;
        end else if (step) begin
            if (at_limit) begin
                tc_d = 1'b1;
                if (SATURATE == 0) begin
                    count_d = bus.dir ? '0 : LIMIT;
                end
            end else begin
                count_d = bus.dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
endmodule
